ad_ip_jesd204_tpl_adc_pnmon: RTL

- Receive-side transport-layer PN monitor. Sits between the JESD204 RX link layer and the ADC TPL core, in the link_clk domain.
- Splits link beats into per-channel 16-bit samples and forwards them one cycle later.
- Checks each enabled channel against a self-synchronising PN9 sequence.
- Reports per-channel out-of-sync (OOS) status, a sticky error flag and a saturating mismatch count, for the regmap to expose.

---
 rtl/ad_ip_jesd204_tpl_adc_pnmon.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_adc_pnmon
// Brief    : RX transport-layer PN9 monitor. Forwards link beats one cycle
//            later and checks every enabled channel against a
//            self-synchronising PN9 sequence, reporting OOS, a sticky error
//            flag and a saturating mismatch count per channel.
// Revision : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_adc_pnmon #(
    parameter int NUM_LANES       = 4,
    parameter int NUM_CHANNELS    = 2,
    parameter int DATA_PATH_WIDTH = 2 * NUM_LANES / NUM_CHANNELS,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       link_valid,
    input  logic [NUM_LANES*32-1:0]    link_data,
    input  logic [NUM_CHANNELS-1:0]    enable,
    input  logic [NUM_CHANNELS-1:0]    pn_err_clr,
    output logic                       adc_valid,
    output logic [NUM_LANES*32-1:0]    adc_data,
    output logic [NUM_CHANNELS-1:0]    pn_oos,
    output logic [NUM_CHANNELS-1:0]    pn_err,
    output logic [NUM_CHANNELS*16-1:0] pn_err_count
);

    localparam int         c_CW      = DATA_PATH_WIDTH * 16;
    localparam logic [7:0] c_THR_M1  = 8'(OOS_THRESHOLD - 1);
    localparam logic [0:0] c_ST_OOS  = 1'b0;
    localparam logic [0:0] c_ST_SYNC = 1'b1;

    // Next 16 PN9 bits following word w (MSB is the earliest bit).
    function automatic logic [15:0] pn9_pred(input logic [15:0] w);
        logic [31:0] e;
        logic [15:0] p;
        e = '0;
        p = '0;
        for (int i = 0; i < 16; i++) e[i] = w[15-i];
        for (int i = 16; i < 32; i++) e[i] = e[i-9] ^ e[i-5];
        for (int j = 0; j < 16; j++) p[15-j] = e[16+j];
        return p;
    endfunction

    // Transparent one-cycle forwarding of the link beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adc_valid <= 1'b0;
            adc_data  <= '0;
        end else begin
            adc_valid <= link_valid;
            adc_data  <= link_data;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [c_CW-1:0]    w_beat;
        logic [c_CW+15:0]   w_chain;
        logic               w_ok;
        logic               w_match;
        logic [0:0]         r_state,     w_state_nxt;
        logic [7:0]         r_match_cnt, w_match_nxt;
        logic [7:0]         r_miss_cnt,  w_miss_nxt;
        logic [15:0]        r_hist,      w_hist_nxt;
        logic               r_hist_vld,  w_hist_vld_nxt;
        logic               r_err,       w_err_nxt;
        logic [15:0]        r_err_cnt,   w_err_cnt_nxt;
        logic               w_err_rec;

        assign w_beat  = link_data[c*c_CW +: c_CW];
        // History word sits below the beat so sample k always pairs with slot k.
        assign w_chain = {w_beat, r_hist};

        // Every sample must be the PN9 successor of the one before it.
        always_comb begin
            w_ok = 1'b1;
            for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
                if (w_chain[(k+1)*16 +: 16] != pn9_pred(w_chain[k*16 +: 16]))
                    w_ok = 1'b0;
            end
        end

        // The all-zero word is a fixed point of the recurrence; never accept it.
        assign w_match = w_ok && r_hist_vld && (w_beat != '0);

        // Next-state, counters, history and error bookkeeping.
        always_comb begin
            w_state_nxt    = r_state;
            w_match_nxt    = r_match_cnt;
            w_miss_nxt     = r_miss_cnt;
            w_hist_nxt     = r_hist;
            w_hist_vld_nxt = r_hist_vld;
            w_err_nxt      = r_err;
            w_err_cnt_nxt  = r_err_cnt;
            w_err_rec      = 1'b0;
            if (!enable[c]) begin
                w_state_nxt    = c_ST_OOS;
                w_match_nxt    = '0;
                w_miss_nxt     = '0;
                w_hist_vld_nxt = 1'b0;
            end else if (link_valid) begin
                w_hist_nxt     = w_beat[c_CW-1 -: 16];
                w_hist_vld_nxt = 1'b1;
                if (r_hist_vld) begin
                    if (r_state == c_ST_OOS) begin
                        if (!w_match) begin
                            w_match_nxt = '0;
                        end else if (r_match_cnt == c_THR_M1) begin
                            w_state_nxt = c_ST_SYNC;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + 8'd1;
                        end
                    end else begin
                        if (w_match) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_err_rec = 1'b1;
                            if (r_miss_cnt == c_THR_M1) begin
                                w_state_nxt = c_ST_OOS;
                                w_miss_nxt  = '0;
                            end else begin
                                w_miss_nxt = r_miss_cnt + 8'd1;
                            end
                        end
                    end
                end
            end
            // A coincident clear discards the mismatch being recorded.
            if (pn_err_clr[c]) begin
                w_err_nxt     = 1'b0;
                w_err_cnt_nxt = '0;
            end else if (w_err_rec) begin
                w_err_nxt = 1'b1;
                if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
            end
        end

        // Per-channel state register.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_state     <= c_ST_OOS;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                r_hist      <= '0;
                r_hist_vld  <= 1'b0;
                r_err       <= 1'b0;
                r_err_cnt   <= '0;
            end else begin
                r_state     <= w_state_nxt;
                r_match_cnt <= w_match_nxt;
                r_miss_cnt  <= w_miss_nxt;
                r_hist      <= w_hist_nxt;
                r_hist_vld  <= w_hist_vld_nxt;
                r_err       <= w_err_nxt;
                r_err_cnt   <= w_err_cnt_nxt;
            end
        end

        assign pn_oos[c]                = (r_state == c_ST_OOS);
        assign pn_err[c]                = r_err;
        assign pn_err_count[c*16 +: 16] = r_err_cnt;
    end

endmodule
`default_nettype wire
